// File: rtl/req_capture_4ch.sv
// Four-channel request capture: synchronise, debounce and rising-edge-detect each raw line.
// Detected edges are queued and granted one at a time as a one-hot word with a valid/ready
// handshake. Build option RR_ARB_EN selects round-robin arbitration; the default is fixed
// priority with channel 3 highest.
module req_capture_4ch #(
    parameter int unsigned DB_CNT = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_raw,
    output logic [3:0] out_onehot,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] pending,
    output logic [3:0] drop,
    input  logic       clr_drop
);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CNT - 1);

    logic [3:0]       s1_q, s2_q;
    logic [3:0]       db_q, db_d;
    logic [3:0]       rise;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       drop_q, drop_d;
    logic [3:0]       oh_q, oh_d;
    logic             valid_q, valid_d;
    logic [3:0]       grant;
    logic             load;

    always_comb begin
        db_d = db_q;
        rise = '0;
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = '0;
            if (s2_q[n] != db_q[n]) begin
                if (cnt_q[n] == CntMax) begin
                    db_d[n] = s2_q[n];
                    rise[n] = s2_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end

`ifdef RR_ARB_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx, sel_idx;
    logic       found;

    // Search begins one past the last grant so every pending channel is served in turn.
    always_comb begin
        found   = 1'b0;
        sel_idx = ptr_q;
        idx     = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && pend_q[idx]) begin
                found   = 1'b1;
                sel_idx = idx;
            end
        end
        grant = found ? (4'b0001 << sel_idx) : 4'b0000;
        ptr_d = (load && found) ? sel_idx : ptr_q;
    end
`else
    // Later iterations overwrite earlier ones, so the highest pending channel wins.
    always_comb begin
        grant = '0;
        for (int i = 0; i < 4; i++) begin
            if (pend_q[i]) begin
                grant = 4'b0001 << i;
            end
        end
    end
`endif

    assign load = !valid_q || out_ready;

    always_comb begin
        oh_d    = oh_q;
        valid_d = valid_q;
        if (load) begin
            oh_d    = grant;
            valid_d = |pend_q;
        end
        // A new edge on the cycle its bit is granted keeps the bit set.
        pend_d = (pend_q & ~(load ? grant : 4'b0000)) | rise;
        drop_d = (clr_drop ? 4'b0000 : drop_q) | (rise & pend_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
            oh_q    <= '0;
            valid_q <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            s1_q    <= in_raw;
            s2_q    <= s1_q;
            db_q    <= db_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            oh_q    <= oh_d;
            valid_q <= valid_d;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

`ifdef RR_ARB_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd3;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign out_onehot = oh_q;
    assign out_valid  = valid_q;
    assign pending    = pend_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_req_capture_4ch.sv
// Bench for req_capture_4ch: directed scenarios plus random traffic against a behavioural
// model built from run lengths of the synchronised samples and a pending-request set.
module tb_req_capture_4ch;
    localparam int DbCnt = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_raw;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending;
    logic [3:0] drop;
    logic       clr_drop;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: raw history (two-stage synchroniser), debounced levels, run lengths.
    logic [3:0] h0, h1, m_db, m_pend, m_drop, m_oh;
    logic       m_valid;
    int         m_run [4];
`ifdef RR_ARB_EN
    int         m_ptr;
`endif

    int         lat;
    logic       saw;
    logic [3:0] seen;
    logic [3:0] raw_r;
    int         hold [4];

    req_capture_4ch #(
        .DB_CNT(DbCnt),
        .CNT_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_raw    (in_raw),
        .out_onehot(out_onehot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .drop      (drop),
        .clr_drop  (clr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] raw, input logic rdy,
                              input logic clr);
        logic [3:0] rise;
        logic [3:0] gnt;
        int         k;
        if (r) begin
            h0 = '0; h1 = '0; m_db = '0; m_pend = '0; m_drop = '0; m_oh = '0;
            m_valid = 1'b0;
            for (int n = 0; n < 4; n++) m_run[n] = 0;
`ifdef RR_ARB_EN
            m_ptr = 3;
`endif
        end else begin
            rise = '0;
            // Level flips once DbCnt consecutive samples disagree with it.
            for (int n = 0; n < 4; n++) begin
                if (h1[n] != m_db[n]) begin
                    m_run[n] = m_run[n] + 1;
                    if (m_run[n] == DbCnt) begin
                        m_db[n]  = h1[n];
                        m_run[n] = 0;
                        rise[n]  = h1[n];
                    end
                end else begin
                    m_run[n] = 0;
                end
            end
            h1 = h0;
            h0 = raw;
            gnt = '0;
            if (!m_valid || rdy) begin
                k = -1;
`ifdef RR_ARB_EN
                for (int i = 1; i <= 4; i++)
                    if (k < 0 && m_pend[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
                if (k >= 0) m_ptr = k;
`else
                for (int i = 3; i >= 0; i--)
                    if (k < 0 && m_pend[i]) k = i;
`endif
                if (k >= 0) gnt[k] = 1'b1;
                m_oh    = gnt;
                m_valid = (k >= 0);
            end
            m_drop = (clr ? 4'b0000 : m_drop) | (rise & m_pend);
            m_pend = (m_pend & ~gnt) | rise;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] raw, input logic rdy, input logic clr);
        rst       = r;
        in_raw    = raw;
        out_ready = rdy;
        clr_drop  = clr;
        @(posedge clk);
        model_step(r, raw, rdy, clr);
        #1;
        check("valid", {3'b000, out_valid}, {3'b000, m_valid});
        check("onehot", out_onehot, m_oh);
        check("pending", pending, m_pend);
        check("drop", drop, m_drop);
    endtask

    initial begin
        rst = 1'b1; in_raw = 4'b1111; out_ready = 1'b1; clr_drop = 1'b0;

        // Reset with all lines high, then release and expect every channel to be granted.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b1, 1'b0);
        check("reset_pending", pending, 4'b0000);
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b1111, 1'b1, 1'b0);
            seen = seen | out_onehot;
        end
        check("all_granted", seen, 4'b1111);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b1, 1'b0);

        // Latency: index 0 is the edge that first samples the rise.
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b0100, 1'b1, 1'b0);
            if (out_valid && lat < 0) begin
                lat = i;
                check("lat_onehot", out_onehot, 4'b0100);
            end
        end
        check_int("latency", lat, 6);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b1, 1'b0);

        // Glitch rejection then acceptance.
        saw = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000, 1'b1, 1'b0);
            saw = saw | out_valid;
        end
        check("glitch_ignored", {3'b000, saw}, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000, 1'b1, 1'b0);
            saw = saw | out_valid;
        end
        check("pulse_accepted", {3'b000, saw}, 4'b0001);

        // Backpressure with two simultaneous requests.
        for (int i = 0; i < 16; i++) step(1'b0, 4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1001, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b1, 1'b0);

        // Drop: channel 3 presented and held, channel 1 queued, second edge on channel 1.
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1010, 1'b0, 1'b0);
        check("drop_set", drop, 4'b0010);
        check("drop_pending", pending, 4'b0010);
        step(1'b0, 4'b1010, 1'b0, 1'b1);
        check("drop_cleared", drop, 4'b0000);
        for (int i = 0; i < 12; i++) step(1'b0, 4'b0000, 1'b1, 1'b0);

        // Random traffic: per-channel hold lengths straddle the debounce threshold.
        raw_r = '0;
        for (int n = 0; n < 4; n++) hold[n] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (hold[n] == 0) begin
                    raw_r[n] = ~raw_r[n];
                    hold[n]  = int'($urandom_range(1, 9));
                end
                hold[n] = hold[n] - 1;
            end
            step(($urandom_range(0, 599) == 0), raw_r, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
            check("onehot_form", {3'b000, $onehot0(out_onehot)}, 4'b0001);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
